// File: rtl/ddc_pkg.sv
// Shared constants and types for the I2S/DDC audio path.
// Frame geometry is fixed: 64 bclk per frame, two 32-bit slots.
package ddc_pkg;

  localparam int FRAME_BITS         = 64;
  localparam int SLOT_BITS          = 32;
  localparam int BIT_IDX_W          = $clog2(FRAME_BITS);
  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] left;
    logic [DEFAULT_DATA_WIDTH-1:0] right;
  } stereo_pair_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact occupancy count. A push while full is refused even
// when a pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop in the
      // design samples pre-edge values regardless of process ordering.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it has
  // been written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: divides clk into bclk, frames 64-bit stereo words with
// the one-bit I2S delay and serialises FIFO-buffered sample pairs MSB first.
module i2s_tx_master
  import ddc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          s_valid,
  input  logic [DATA_WIDTH-1:0]         s_left,
  input  logic [DATA_WIDTH-1:0]         s_right,
  output logic                          s_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          underrun_clr,
  output logic                          underrun,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdout
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = BIT_IDX_W;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] R_SLOT   = BW'(SLOT_BITS);
  localparam logic [BW-1:0] L_FIRST  = BW'(1);
  localparam logic [BW-1:0] L_LAST   = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] R_FIRST  = BW'(SLOT_BITS + 1);
  localparam logic [BW-1:0] R_LAST   = BW'(SLOT_BITS + DATA_WIDTH);

  logic [CW-1:0] count;
  logic [BW-1:0] bit_idx;
  logic [BW-1:0] bit_next;
  logic [PW-1:0] shift_q;
  logic [PW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          tick;
  logic          fall;
  logic          frame_load;
  logic          data_slot;

  sync_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .wdata ({s_left, s_right}),
    .pop   (frame_load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign s_ready = !fifo_full;

  // All serial updates happen on the bclk 1->0 toggle so data is stable at the
  // receiver's rising-edge sample point.
  assign tick       = (count == CNT_LAST);
  assign fall       = en && tick && bclk;
  assign bit_next   = (bit_idx == B_LAST) ? '0 : bit_idx + BW'(1);
  assign frame_load = fall && (bit_idx == B_LAST);
  assign data_slot  = ((bit_next >= L_FIRST) && (bit_next <= L_LAST)) ||
                      ((bit_next >= R_FIRST) && (bit_next <= R_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      bclk    <= 1'b0;
      bit_idx <= B_LAST;
      lrclk   <= 1'b0;
      sdout   <= 1'b0;
      shift_q <= '0;
    end else if (!en) begin
      // Idle parks at b=63 so the first fall after enable opens a fresh frame.
      count   <= '0;
      bclk    <= 1'b0;
      bit_idx <= B_LAST;
      lrclk   <= 1'b0;
      sdout   <= 1'b0;
      shift_q <= '0;
    end else begin
      if (tick) begin
        count <= '0;
        bclk  <= !bclk;
      end else begin
        count <= count + CW'(1);
      end

      if (fall) begin
        bit_idx <= bit_next;
        lrclk   <= (bit_next >= R_SLOT);
        if (frame_load) begin
          // An empty FIFO sends a silent frame rather than stale data.
          shift_q <= fifo_empty ? '0 : fifo_rdata;
          sdout   <= 1'b0;
        end else if (data_slot) begin
          // Left occupies the top half, so after DATA_WIDTH shifts the right
          // sample's MSB is already in place for the second slot.
          sdout   <= shift_q[PW-1];
          shift_q <= {shift_q[PW-2:0], 1'b0};
        end else begin
          sdout   <= 1'b0;
        end
      end
    end
  end

  // Set has priority over clear so a coinciding underrun is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun <= 1'b0;
    end else if (frame_load && fifo_empty) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed bench for i2s_tx_master: an I2S receiver model rebuilds frames from the
// serial pins and a scoreboard matches them against the pairs pushed in.
`timescale 1ns/1ps
module tb_i2s_tx_master;
  import ddc_pkg::*;

  localparam int DW       = 16;
  localparam int CLK_DIV  = 2;
  localparam int DEPTH    = 4;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int CLK_NS   = 10;
  localparam longint FRAME_NS = 64 * 2 * CLK_DIV * CLK_NS;
  localparam int TIMEOUT  = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          s_valid = 1'b0;
  logic          underrun_clr = 1'b0;
  logic [DW-1:0] s_left = '0;
  logic [DW-1:0] s_right = '0;
  logic          s_ready;
  logic [LW-1:0] fifo_level;
  logic          underrun;
  logic          bclk;
  logic          lrclk;
  logic          sdout;

  i2s_tx_master #(
    .DATA_WIDTH (DW),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s_valid      (s_valid),
    .s_left       (s_left),
    .s_right      (s_right),
    .s_ready      (s_ready),
    .fifo_level   (fifo_level),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdout        (sdout)
  );

  always #(CLK_NS / 2) clk = ~clk;

  typedef struct {
    stereo_pair_t pair;
    logic         fmt_ok;
    longint       period;
  } rx_frame_t;

  stereo_pair_t want_q[$];
  rx_frame_t    rx_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           sync_req = 0;
  longint       last_period = 0;

  // Receiver model: samples on bclk rise; a resync request marks the next rise as
  // the idle b=63 slot, so the rise after it is b=0.
  int            sync_seen = 0;
  int            mon_pos = 62;
  logic          mon_have = 1'b0;
  logic          mon_fmt = 1'b1;
  logic [DW-1:0] cur_l = '0;
  logic [DW-1:0] cur_r = '0;
  longint        start_t = 0;
  longint        cur_period = 0;

  always @(posedge bclk) begin
    #1;
    if (sync_seen != sync_req) begin
      sync_seen = sync_req;
      mon_pos   = 62;
      mon_have  = 1'b0;
      start_t   = 0;
    end
    mon_pos = (mon_pos == 63) ? 0 : mon_pos + 1;
    if (mon_pos == 0) begin
      mon_have   = 1'b1;
      mon_fmt    = 1'b1;
      cur_l      = '0;
      cur_r      = '0;
      cur_period = (start_t != 0) ? $time - start_t : 0;
      start_t    = $time;
    end
    if (mon_have) begin
      if (lrclk !== (mon_pos >= 32)) mon_fmt = 1'b0;
      if (mon_pos >= 1 && mon_pos <= DW)            cur_l = {cur_l[DW-2:0], sdout};
      else if (mon_pos >= 33 && mon_pos <= 32 + DW) cur_r = {cur_r[DW-2:0], sdout};
      else if (sdout !== 1'b0)                      mon_fmt = 1'b0;
      if (mon_pos == 63)
        rx_q.push_back('{pair: '{left: cur_l, right: cur_r}, fmt_ok: mon_fmt, period: cur_period});
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_push(input logic [DW-1:0] l, input logic [DW-1:0] r, output logic accepted);
    s_valid  = 1'b1;
    s_left   = l;
    s_right  = r;
    accepted = s_ready;
    if (accepted) want_q.push_back('{left: l, right: r});
    step(1);
    s_valid = 1'b0;
  endtask

  task automatic get_frame(input string tag);
    int           n = 0;
    rx_frame_t    f;
    stereo_pair_t w;
    while (rx_q.size() == 0 && n < TIMEOUT) begin
      step(1);
      n++;
    end
    check({tag, "_arrived"}, 32'(rx_q.size() != 0), 32'd1);
    if (rx_q.size() == 0) return;
    f = rx_q.pop_front();
    w = (want_q.size() != 0) ? want_q.pop_front() : '1;
    last_period = f.period;
    check({tag, "_data"}, f.pair, w);
    check({tag, "_fmt"}, 32'(f.fmt_ok), 32'd1);
  endtask

  task automatic wait_pos(input string tag, input int p);
    int n = 0;
    while (!(mon_have && mon_pos == p) && n < TIMEOUT) begin
      step(1);
      n++;
    end
    check({tag, "_reached"}, 32'(mon_have && mon_pos == p), 32'd1);
  endtask

  task automatic wait_lr_rise(input string tag);
    int   n = 0;
    logic prev;
    prev = lrclk;
    step(1);
    while (!(!prev && lrclk) && n < TIMEOUT) begin
      prev = lrclk;
      step(1);
      n++;
    end
    check({tag, "_seen"}, 32'(!prev && lrclk), 32'd1);
  endtask

  task automatic wait_bclk_fall(input string tag);
    int   n = 0;
    logic prev;
    prev = bclk;
    step(1);
    while (!(prev && !bclk) && n < TIMEOUT) begin
      prev = bclk;
      step(1);
      n++;
    end
    check({tag, "_seen"}, 32'(prev && !bclk), 32'd1);
  endtask

  initial begin
    logic acc;

    // Reset state
    step(3);
    check("rst_bclk", 32'(bclk), 0);
    check("rst_lrclk", 32'(lrclk), 0);
    check("rst_sdout", 32'(sdout), 0);
    check("rst_ready", 32'(s_ready), 1);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_underrun", 32'(underrun), 0);
    rst = 1'b1;
    step(2);

    // 1: basic frame
    drive_push(16'hA5C3, 16'h1234, acc);
    check("t1_acc", 32'(acc), 1);
    check("t1_level", 32'(fifo_level), 1);
    sync_req++;
    en = 1'b1;
    get_frame("t1");
    en = 1'b0;
    check("t1_underrun", 32'(underrun), 0);
    step(2);

    // 2: FIFO full, back-to-back pushes with en low
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_left  = 16'(16'h1101 * (i + 1));
      s_right = ~s_left;
      check($sformatf("t2_ready%0d", i), 32'(s_ready), 32'(i < DEPTH));
      if (s_ready) want_q.push_back('{left: s_left, right: s_right});
      step(1);
    end
    s_valid = 1'b0;
    check("t2_level_full", 32'(fifo_level), DEPTH);
    sync_req++;
    en = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      get_frame($sformatf("t2_f%0d", k));
      if (k == DEPTH - 1) en = 1'b0;
      check($sformatf("t2_level%0d", k), 32'(fifo_level), 32'(DEPTH - 1 - k));
      if (k > 0) check($sformatf("t2_period%0d", k), 32'(last_period), 32'(FRAME_NS));
    end
    step(2);

    // 3: underrun, clear, recovery
    check("t3_underrun_pre", 32'(underrun), 0);
    want_q.push_back('0);
    sync_req++;
    en = 1'b1;
    get_frame("t3_zero");
    en = 1'b0;
    check("t3_underrun_set", 32'(underrun), 1);
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    check("t3_underrun_clr", 32'(underrun), 0);
    drive_push(16'h7FFF, 16'h8000, acc);
    sync_req++;
    en = 1'b1;
    get_frame("t3_pair");
    en = 1'b0;
    check("t3_underrun_after", 32'(underrun), 0);
    step(2);

    // 4a: push lands on the same edge as a load from an empty FIFO
    want_q.push_back('0);
    sync_req++;
    en = 1'b1;
    step(2 * CLK_DIV - 1);
    s_valid = 1'b1;
    s_left  = 16'hBEEF;
    s_right = 16'h0F0F;
    want_q.push_back('{left: 16'hBEEF, right: 16'h0F0F});
    step(1);
    s_valid = 1'b0;
    check("t4_underrun", 32'(underrun), 1);
    check("t4_level", 32'(fifo_level), 1);
    get_frame("t4_zero");
    step(4);
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    check("t4_clr", 32'(underrun), 0);

    // 4b: clear coincides with the next empty load (32 falls after lrclk rises)
    wait_lr_rise("t4_lr");
    step(32 * 2 * CLK_DIV - 1);
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    en = 1'b0;
    check("t4_set_wins", 32'(underrun), 1);
    get_frame("t4_pair");
    step(2);

    // 5: reset mid-frame
    drive_push(16'h5A5A, 16'hC3C3, acc);
    sync_req++;
    en = 1'b1;
    wait_pos("t5_b20", 20);
    rst = 1'b0;
    #1;
    check("t5_bclk", 32'(bclk), 0);
    check("t5_lrclk", 32'(lrclk), 0);
    check("t5_sdout", 32'(sdout), 0);
    check("t5_ready", 32'(s_ready), 1);
    check("t5_level", 32'(fifo_level), 0);
    check("t5_underrun", 32'(underrun), 0);
    want_q.delete();
    step(3);
    want_q.push_back('0);
    sync_req++;
    rst = 1'b1;
    wait_bclk_fall("t5_fall");
    check("t5_first_lrclk", 32'(lrclk), 0);
    get_frame("t5_zero");
    en = 1'b0;
    step(2);

    // 6: drop en mid-frame with two pairs queued behind the one on the wire
    drive_push(16'h1111, 16'h2222, acc);
    drive_push(16'h3333, 16'h4444, acc);
    drive_push(16'h5555, 16'h6666, acc);
    sync_req++;
    en = 1'b1;
    wait_pos("t6_b40", 40);
    en = 1'b0;
    void'(want_q.pop_front());
    step(1);
    check("t6_bclk", 32'(bclk), 0);
    check("t6_lrclk", 32'(lrclk), 0);
    check("t6_sdout", 32'(sdout), 0);
    check("t6_level", 32'(fifo_level), 2);
    step(3);
    sync_req++;
    en = 1'b1;
    get_frame("t6_p2");
    check("t6_level_p2", 32'(fifo_level), 1);
    get_frame("t6_p3");
    en = 1'b0;
    check("t6_level_p3", 32'(fifo_level), 0);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_tx_master.md
Name: i2s_tx_master

Overview:
- I2S master transmitter that generates bclk, lrclk and serial data from buffered parallel stereo samples.
- Directly upstream of the DDC: drives its bclk/lrclk/sdin inputs, producing 64 bclk per frame (32-bit slots, 16-bit data, I2S one-bit delay).
- Used as the on-chip audio source and as the bench stimulus generator for DDC-level regressions.
- Runs from a system clock at 4x bclk by default (12.288 MHz -> 3.072 MHz bclk, 48 kHz lrclk).

Parameters:
DATA_WIDTH, 16, sample width per channel; must be <= 31.
CLK_DIV, 2, clk cycles per bclk half-period; must be >= 1.
FIFO_DEPTH, 4, stereo-frame FIFO entries; must be a power of two, >= 2.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
en  in  1  run enable; low = serial outputs idle.
s_valid  in  1  sample-pair push request.
s_left  in  DATA_WIDTH  signed left sample.
s_right  in  DATA_WIDTH  signed right sample.
s_ready  out  1  FIFO not full.
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held.
underrun_clr  in  1  clears the sticky underrun flag.
underrun  out  1  sticky: a frame load found the FIFO empty.
bclk  out  1  bit clock (registered).
lrclk  out  1  word select: 0 = left, 1 = right (registered).
sdout  out  1  serial data, changes on bclk falling edge (registered).

Behaviour:
- Reset state (rst low, asynchronous):
  - bclk=0, lrclk=0, sdout=0, s_ready=1, fifo_level=0, underrun=0.
  - Divider count=0; bit index b=63; FIFO emptied; shift register cleared.
- Divider:
  - When en=1, count runs 0..CLK_DIV-1; bclk toggles on the cycle count wraps.
  - bclk period = 2*CLK_DIV clk.
  - A 1->0 toggle is a "fall event". All lrclk/sdout updates and b advances happen in the same cycle as the fall event, so the receiver samples stable data on the rising edge.
- Fall event:
  - b <= (b==63) ? 0 : b+1.
  - lrclk <= (new b >= 32).
  - sdout by new b:
    - b=1..DATA_WIDTH: left bit [DATA_WIDTH-b] (MSB first).
    - b=33..32+DATA_WIDTH: right bit [DATA_WIDTH-(b-32)].
    - All other b: 0.
- Frame load at the fall event entering b=0:
  - If FIFO non-empty: pop one entry into the left/right holding registers.
  - If FIFO empty: load zeros and set underrun.
- underrun:
  - Sticky until an underrun_clr cycle.
  - If a set and underrun_clr occur in the same cycle, set wins.
- FIFO:
  - Synchronous, first-word-fall-through not required.
  - Push when s_valid && s_ready.
  - s_ready = !full, computed from registered state. A push while full is refused even if a pop occurs the same cycle.
  - Simultaneous push and pop on a non-empty, non-full FIFO: level unchanged.
  - Pop on empty with simultaneous push: underrun fires, the pushed entry is stored, level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level is exact, 0..FIFO_DEPTH.
- en=0:
  - Next cycle: bclk=0, lrclk=0, sdout=0, count=0, b=63, holding registers cleared.
  - FIFO contents, pushes and underrun are unaffected.
  - On en returning to 1, the first fall event occurs 2*CLK_DIV clk later and loads a fresh frame at b=0.
- Latency: a pair pushed into an empty FIFO appears at the next b=0 load. Its MSB is on sdout one bclk after the lrclk 1->0 edge.
- Reset mid-frame aborts immediately. No partial frame resumes.

Decomposition:
- Shared package ddc_pkg:
  - FRAME_BITS=64, SLOT_BITS=32.
  - Default DATA_WIDTH=16.
  - Stereo-pair typedef {left, right}.
- One sub-module: sync_fifo, with parameters WIDTH=2*DATA_WIDTH and DEPTH=FIFO_DEPTH, ports push/pop/full/empty/level.
- The divider, bit index and shift/serialiser logic stay in i2s_tx_master.

Test Plan:
1. Basic frame (CLK_DIV=2): push L=16'hA5C3, R=16'h1234, then en=1 -> 256 clk per frame; lrclk low for b=0..31; sdout at b=1..16 = 1010_0101_1100_0011; b=33..48 = 0001_0010_0011_0100; zeros elsewhere; underrun stays 0.
2. FIFO full: push 5 pairs back-to-back with en=0 -> first 4 accepted, fifo_level=4, s_ready=0 on the 5th. Then en=1 -> level drops by 1 per frame and the frames appear in push order.
3. Underrun: en=1 with an empty FIFO -> zero frame transmitted, underrun=1 after the first b=0 load. Pulse underrun_clr -> 0. Push 16'h7FFF/16'h8000 -> the next frame carries them, underrun stays 0.
4. Simultaneous events: push arrives the same cycle as a b=0 load on an empty FIFO -> underrun=1, fifo_level=1, pair sent the following frame. underrun_clr coinciding with a new underrun -> underrun remains 1.
5. Reset mid-frame: assert rst at b=20 -> all outputs 0 asynchronously, FIFO empty. After release with en=1, the first fall event gives b=0 and lrclk=0.
6. en toggle: drop en at b=40 with 2 entries queued -> outputs 0 within 1 clk, fifo_level stays 2. Re-enable -> a clean frame starts at b=0 with the next queued pair.
